// File: rtl/enhanced_pwm_pkg.sv
// Shared defaults and the output-level rule for the enhanced PWM block.
package enhanced_pwm_pkg;

    localparam int DEFAULT_R          = 5;
    localparam int DEFAULT_TIMER_BITS = 8;

    // High while the current step index is below the duty word; forced low when held.
    function automatic logic pwm_level(input logic enable, input logic [31:0] q, input logic [31:0] duty);
        logic level_s;
        if (enable) begin
            level_s = (q < duty);
        end else begin
            level_s = 1'b0;
        end
        return level_s;
    endfunction

endpackage

// File: rtl/enhanced_pwm_if.sv
// Control/output bundle of the PWM generator: run control, step length, duty word and pin.
interface enhanced_pwm_if
    import enhanced_pwm_pkg::*;
#(
    parameter int R          = DEFAULT_R,
    parameter int TIMER_BITS = DEFAULT_TIMER_BITS
);
    logic                  enable;
    logic [TIMER_BITS-1:0] FINAL_VALUE;
    logic [R:0]            duty;
    logic                  pwm_out;

    modport master (output enable, output FINAL_VALUE, output duty, input pwm_out);
    modport slave  (input enable, input FINAL_VALUE, input duty, output pwm_out);
endinterface

// File: rtl/pwm_prescaler.sv
// Step-length prescaler: one-cycle tick every FINAL_VALUE+1 enabled clocks.
module pwm_prescaler
    import enhanced_pwm_pkg::*;
#(
    parameter int TIMER_BITS = DEFAULT_TIMER_BITS
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic [TIMER_BITS-1:0] FINAL_VALUE,
    output logic                  tick
);

    logic [TIMER_BITS-1:0] count_r;
    logic                  tick_s;

    // Terminal-count detect; >= lets a lowered FINAL_VALUE wrap the count at once.
    always_comb begin
        if (enable) begin
            tick_s = (count_r >= FINAL_VALUE);
        end else begin
            tick_s = 1'b0;
        end
    end

    // Step counter: clears on tick, advances while enabled, otherwise holds.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_r <= {TIMER_BITS{1'b0}};
        end else if (tick_s) begin
            count_r <= {TIMER_BITS{1'b0}};
        end else if (enable) begin
            count_r <= count_r + {{(TIMER_BITS-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign tick = tick_s;

endmodule

// File: rtl/enhanced_pwm.sv
// Programmable-frequency, programmable-duty PWM generator with registered output.
module enhanced_pwm
    import enhanced_pwm_pkg::*;
#(
    parameter int R          = DEFAULT_R,
    parameter int TIMER_BITS = DEFAULT_TIMER_BITS
) (
    input  logic          clk,
    input  logic          reset_n,
    enhanced_pwm_if.slave pwm
);

    logic         tick_s;
    logic [R-1:0] q_r;
    logic         level_s;
    logic         pwm_out_r;

    pwm_prescaler #(.TIMER_BITS(TIMER_BITS)) u_prescaler (
        .clk         (clk),
        .reset_n     (reset_n),
        .enable      (pwm.enable),
        .FINAL_VALUE (pwm.FINAL_VALUE),
        .tick        (tick_s)
    );

    // Duty step counter; wraps naturally from 2^R-1 to 0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q_r <= {R{1'b0}};
        end else if (tick_s) begin
            q_r <= q_r + {{(R-1){1'b0}}, 1'b1};
        end else begin
            q_r <= q_r;
        end
    end

    // Duty word is one bit wider than Q so that duty >= 2^R means always high.
    always_comb begin
        level_s = pwm_level(pwm.enable, 32'(q_r), 32'(pwm.duty));
    end

    // Output register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pwm_out_r <= 1'b0;
        end else begin
            pwm_out_r <= level_s;
        end
    end

    assign pwm.pwm_out = pwm_out_r;

endmodule

// File: tb/tb_enhanced_pwm.sv
// Randomised and directed bench for enhanced_pwm against a step/period reference model.
module tb_enhanced_pwm;

    localparam int R     = 5;
    localparam int TB    = 8;
    localparam int STEPS = 1 << R;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    enhanced_pwm_if #(.R(R), .TIMER_BITS(TB)) pif ();

    enhanced_pwm #(.R(R), .TIMER_BITS(TB)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .pwm     (pif)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    int hi_acc   = 0;

    // Reference state: position within the current step and step index within the period.
    int m_step_pos = 0;
    int m_step_idx = 0;
    int m_pwm      = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_step_pos = 0;
        m_step_idx = 0;
        m_pwm      = 0;
    endtask

    // One clock: advance the reference at the rising edge, compare on the falling edge.
    task automatic cycle();
        @(posedge clk);
        if (!reset_n) begin
            model_clear();
        end else begin
            m_pwm = (pif.enable === 1'b1 && m_step_idx < int'(pif.duty)) ? 1 : 0;
            if (pif.enable === 1'b1) begin
                if (m_step_pos >= int'(pif.FINAL_VALUE)) begin
                    m_step_pos = 0;
                    m_step_idx = (m_step_idx + 1) % STEPS;
                end else begin
                    m_step_pos = m_step_pos + 1;
                end
            end
        end
        @(negedge clk);
        check("pwm_vs_model", {31'd0, pif.pwm_out}, m_pwm);
        if (pif.pwm_out === 1'b1) hi_acc++;
    endtask

    task automatic do_reset();
        reset_n    = 1'b0;
        pif.enable = 1'b0;
        model_clear();
        repeat (2) cycle();
        reset_n = 1'b1;
        cycle();
    endtask

    task automatic measure(input string name, input int fv, input int dv, input int exp_hi);
        int period;
        do_reset();
        pif.FINAL_VALUE = TB'(fv);
        pif.duty        = (R+1)'(dv);
        pif.enable      = 1'b1;
        period = STEPS * (fv + 1);
        for (int p = 0; p < 2; p++) begin
            hi_acc = 0;
            repeat (period) cycle();
            check(name, hi_acc, exp_hi);
        end
    endtask

    initial begin
        pif.enable      = 1'b0;
        pif.FINAL_VALUE = 8'd0;
        pif.duty        = 6'd0;
        repeat (3) cycle();
        check("reset_pwm", {31'd0, pif.pwm_out}, 32'd0);
        check("reset_q", {27'd0, dut.q_r}, 32'd0);

        // Nominal: FINAL_VALUE=255, duty=16 -> 4096 high per 8192-clock period.
        reset_n = 1'b1;
        cycle();
        pif.FINAL_VALUE = 8'd255;
        pif.duty        = 6'd16;
        pif.enable      = 1'b1;
        hi_acc = 0;
        cycle();
        check("first_rise", {31'd0, pif.pwm_out}, 32'd1);
        repeat (8191) cycle();
        check("nominal_high_p0", hi_acc, 32'd4096);
        hi_acc = 0;
        repeat (8192) cycle();
        check("nominal_high_p1", hi_acc, 32'd4096);

        // Asynchronous reset mid-run: 600 clocks in, Q=2 and count=88.
        repeat (600) cycle();
        check("pre_reset_high", {31'd0, pif.pwm_out}, 32'd1);
        check("pre_reset_cnt", {24'd0, dut.u_prescaler.count_r}, 32'd88);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_pwm", {31'd0, pif.pwm_out}, 32'd0);
        check("async_rst_q", {27'd0, dut.q_r}, 32'd0);
        check("async_rst_cnt", {24'd0, dut.u_prescaler.count_r}, 32'd0);
        model_clear();
        @(negedge clk);

        measure("fast_duty8", 0, 8, 8);
        measure("duty0", 3, 0, 0);
        measure("duty32", 3, 32, 128);
        measure("duty63", 3, 63, 128);
        measure("duty31", 3, 31, 124);

        // Enable hold for 20 clocks after 30 enabled clocks (count=2, Q=7).
        do_reset();
        pif.FINAL_VALUE = 8'd3;
        pif.duty        = 6'd16;
        pif.enable      = 1'b1;
        hi_acc = 0;
        repeat (30) cycle();
        pif.enable = 1'b0;
        cycle();
        check("hold_drop_next", {31'd0, pif.pwm_out}, 32'd0);
        pif.duty        = 'x;
        pif.FINAL_VALUE = 'x;
        repeat (19) cycle();
        check("hold_q", {27'd0, dut.q_r}, 32'd7);
        check("hold_cnt", {24'd0, dut.u_prescaler.count_r}, 32'd2);
        pif.FINAL_VALUE = 8'd3;
        pif.duty        = 6'd16;
        pif.enable      = 1'b1;
        repeat (98) cycle();
        check("hold_total_high", hi_acc, 32'd64);

        // On-the-fly duty 8 -> 24, then FINAL_VALUE 3 -> 1.
        do_reset();
        pif.FINAL_VALUE = 8'd3;
        pif.duty        = 6'd8;
        pif.enable      = 1'b1;
        repeat (50) cycle();
        pif.duty = 6'd24;
        repeat (78) cycle();
        hi_acc = 0;
        repeat (128) cycle();
        check("duty_change_high", hi_acc, 32'd96);
        repeat (40) cycle();
        pif.FINAL_VALUE = 8'd1;
        repeat (128) cycle();
        hi_acc = 0;
        repeat (64) cycle();
        check("fv_change_high_a", hi_acc, 32'd48);
        hi_acc = 0;
        repeat (64) cycle();
        check("fv_change_high_b", hi_acc, 32'd48);

        // Randomised run: enable toggling, live parameter changes, X while held.
        do_reset();
        pif.FINAL_VALUE = TB'($urandom_range(7, 0));
        pif.duty        = (R+1)'($urandom_range(63, 0));
        pif.enable      = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(15, 0) == 0) begin
                if (pif.enable === 1'b1) begin
                    pif.enable      = 1'b0;
                    pif.duty        = 'x;
                    pif.FINAL_VALUE = 'x;
                end else begin
                    pif.enable      = 1'b1;
                    pif.FINAL_VALUE = TB'($urandom_range(7, 0));
                    pif.duty        = (R+1)'($urandom_range(63, 0));
                end
            end else if (pif.enable === 1'b1 && $urandom_range(49, 0) == 0) begin
                pif.FINAL_VALUE = TB'($urandom_range(7, 0));
                pif.duty        = (R+1)'($urandom_range(63, 0));
            end
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
